// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the execute stage.
//               Each cycle it retires one bit: shift-add multiply or
//               restoring divide. A start/done handshake controls it.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int c_cw = $clog2(XLEN + 1);
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(XLEN);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
    localparam logic [XLEN-1:0] c_min_neg  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] c_op_mul    = 3'd0;
    localparam logic [2:0] c_op_mulh   = 3'd1;
    localparam logic [2:0] c_op_mulhsu = 3'd2;
    localparam logic [2:0] c_op_mulhu  = 3'd3;
    localparam logic [2:0] c_op_div    = 3'd4;
    localparam logic [2:0] c_op_divu   = 3'd5;
    localparam logic [2:0] c_op_rem    = 3'd6;
    localparam logic [2:0] c_op_remu   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_res;
    logic [2:0]          r_op;
    logic                r_neg;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [c_cw-1:0]     r_cnt;

    // ---------------- operand preparation (IDLE) ----------------
    logic                w_sgn1;
    logic                w_sgn2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_neg_init;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;

    assign w_sgn1 = ((op == c_op_mulh) || (op == c_op_mulhsu) ||
                     (op == c_op_div)  || (op == c_op_rem)) && op1[XLEN-1];
    assign w_sgn2 = ((op == c_op_mulh) || (op == c_op_div) ||
                     (op == c_op_rem)) && op2[XLEN-1];
    assign w_mag1 = w_sgn1 ? (~op1 + 1'b1) : op1;
    assign w_mag2 = w_sgn2 ? (~op2 + 1'b1) : op2;

    // Remainder takes the dividend's sign; everything else takes the XOR.
    assign w_neg_init = (op == c_op_rem) ? w_sgn1 : (w_sgn1 ^ w_sgn2);

    assign w_div_zero = (op2 == '0);
    assign w_ovf      = ((op == c_op_div) || (op == c_op_rem)) &&
                        (op1 == c_min_neg) && (op2 == '1);
    assign w_special  = op[2] && (w_div_zero || w_ovf);

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op[1] ? op1 : '1;
        end else begin
            w_special_res = op[1] ? '0 : op1;
        end
    end

    // ---------------- one iteration of the unsigned core ----------------
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_shift;
    logic [XLEN:0]       w_div_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_iter;
    logic [2*XLEN-1:0]   w_signed;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_calc_res;

    // Multiply: r_acc = {partial, multiplier}; r_b = multiplicand.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: r_acc = {remainder, quotient/dividend}; r_b = divisor.
    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_next  = w_div_diff[XLEN] ?
                         {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} :
                         {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

    assign w_iter    = r_op[2] ? w_div_next : w_mul_next;
    // The low half of the negated double-width value equals the negated quotient.
    assign w_signed  = r_neg ? (~w_iter + 1'b1) : w_iter;
    assign w_rem     = w_iter[2*XLEN-1:XLEN];
    assign w_rem_fix = r_neg ? (~w_rem + 1'b1) : w_rem;

    always_comb begin
        w_calc_res = '0;
        case (r_op)
            c_op_mul:                           w_calc_res = w_iter[XLEN-1:0];
            c_op_mulh, c_op_mulhsu, c_op_mulhu: w_calc_res = w_signed[2*XLEN-1:XLEN];
            c_op_div, c_op_divu:                w_calc_res = w_signed[XLEN-1:0];
            c_op_rem, c_op_remu:                w_calc_res = w_rem_fix;
            default:                            w_calc_res = '0;
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == c_cnt_one) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
            r_op    <= '0;
            r_neg   <= 1'b0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_neg <= w_neg_init;
                        r_b   <= op[2] ? w_mag2 : w_mag1;
                        r_acc <= {{XLEN{1'b0}}, (op[2] ? w_mag1 : w_mag2)};
                        r_cnt <= c_cnt_init;
                        if (w_special) begin
                            r_res <= w_special_res;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= w_iter;
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_res <= w_calc_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign res  = r_res;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit at XLEN=32 and XLEN=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start8;
    logic [2:0]  op32, op8;
    logic [31:0] a32, b32, res32;
    logic [7:0]  a8, b8, res8;
    logic        busy32, done32, busy8, done8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32),
        .op1(a32), .op2(b32), .busy(busy32), .done(done32), .res(res32)
    );

    muldiv_unit #(.XLEN(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .op1(a8), .op2(b8), .busy(busy8), .done(done8), .res(res8)
    );

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic longint unsigned model(input int w, input logic [2:0] op,
                                              input longint unsigned a,
                                              input longint unsigned b);
        longint unsigned mask;
        longint          sa, sb, ub, p, smin;
        longint unsigned up;
        mask = (64'd1 << w) - 64'd1;
        sa   = a[w-1] ? (longint'(a) - longint'(64'd1 << w)) : longint'(a);
        sb   = b[w-1] ? (longint'(b) - longint'(64'd1 << w)) : longint'(b);
        ub   = longint'(b);
        smin = -longint'(64'd1 << (w-1));
        case (op)
            3'd0: begin up = a * b; return up & mask; end
            3'd1: begin p = sa * sb; p = p >>> w; return longint'(p) & mask; end
            3'd2: begin p = sa * ub; p = p >>> w; return longint'(p) & mask; end
            3'd3: begin up = a * b; return (up >> w) & mask; end
            3'd4: begin
                if (b == 0) return mask;
                if (sa == smin && sb == -1) return a;
                p = sa / sb; return longint'(p) & mask;
            end
            3'd5: return (b == 0) ? mask : (a / b);
            3'd6: begin
                if (b == 0) return a;
                if (sa == smin && sb == -1) return 0;
                p = sa % sb; return longint'(p) & mask;
            end
            default: return (b == 0) ? a : (a % b);
        endcase
    endfunction

    function automatic int exp_lat(input int w, input logic [2:0] op,
                                   input longint unsigned a, input longint unsigned b);
        longint unsigned smin_u, all1;
        smin_u = 64'd1 << (w-1);
        all1   = (64'd1 << w) - 64'd1;
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == smin_u && b == all1) return 1;
        return w + 1;
    endfunction

    // Issues one operation from the current cycle and waits for its done pulse.
    task automatic do_op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output int lat,
                           output bit busy_ok, output bit post_ok);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(posedge clk); #1;
        start32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
        lat = 1; busy_ok = 1'b1; post_ok = 1'b0; r = '0;
        while (!done32 && lat < 100) begin
            if (busy32 !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (done32 !== 1'b1) begin
            lat = -1;
        end else begin
            if (busy32 !== 1'b1) busy_ok = 1'b0;
            r = res32;
            @(posedge clk); #1;
            post_ok = (busy32 === 1'b0) && (done32 === 1'b0) && (res32 === r);
        end
    endtask

    task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output int lat,
                          output bit busy_ok, output bit post_ok);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 1; busy_ok = 1'b1; post_ok = 1'b0; r = '0;
        while (!done8 && lat < 100) begin
            if (busy8 !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (done8 !== 1'b1) begin
            lat = -1;
        end else begin
            if (busy8 !== 1'b1) busy_ok = 1'b0;
            r = res8;
            @(posedge clk); #1;
            post_ok = (busy8 === 1'b0) && (done8 === 1'b0) && (res8 === r);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy32, done32, res32} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset32: got busy=%b done=%b res=%h want 0/0/0", busy32, done32, res32);
        end
        n_checks++;
        if ({busy8, done8, res8} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b res=%h want 0/0/0", busy8, done8, res8);
        end
        // start coinciding with reset must be dropped
        start32 = 1'b1; op32 = 3'd0; a32 = 32'd3; b32 = 32'd3;
        @(posedge clk); #1;
        reset = 1'b0; start32 = 1'b0;
        n_checks++;
        if (busy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_reset: got busy=%b want 0", busy32);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat; bit bok, pok;
        do_op32(3'd0, -32'sd16, -32'sd5, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'd80 || lat != 33) begin
            n_fail++;
            $display("FAIL mul_neg16_neg5: got res=%h lat=%0d want res=00000050 lat=33", r, lat);
        end
        n_checks++;
        if (!bok || !pok) begin
            n_fail++;
            $display("FAIL mul_busy_window: got busy_ok=%b post_ok=%b want 1/1", bok, pok);
        end
    endtask

    task automatic test_mulh();
        logic [31:0] r; int lat; bit bok, pok;
        do_op32(3'd1, 32'h8000_0000, 32'h8000_0000, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'h4000_0000 || lat != 33) begin
            n_fail++;
            $display("FAIL mulh_min_min: got res=%h lat=%0d want 40000000 lat=33", r, lat);
        end
        do_op32(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'hFFFF_FFFE || lat != 33) begin
            n_fail++;
            $display("FAIL mulhu_max_max: got res=%h lat=%0d want fffffffe lat=33", r, lat);
        end
        do_op32(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'hFFFF_FFFF || lat != 33) begin
            n_fail++;
            $display("FAIL mulhsu_m1_2: got res=%h lat=%0d want ffffffff lat=33", r, lat);
        end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat; bit bok, pok;
        do_op32(3'd4, -32'sd21, 32'd5, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'hFFFF_FFFC || lat != 33) begin
            n_fail++;
            $display("FAIL div_m21_5: got res=%h lat=%0d want fffffffc lat=33", r, lat);
        end
        do_op32(3'd6, -32'sd21, 32'd5, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'hFFFF_FFFF || lat != 33) begin
            n_fail++;
            $display("FAIL rem_m21_5: got res=%h lat=%0d want ffffffff lat=33", r, lat);
        end
        do_op32(3'd5, 32'hFFFF_FFF0, 32'd16, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'h0FFF_FFFF || lat != 33) begin
            n_fail++;
            $display("FAIL divu_fff0_16: got res=%h lat=%0d want 0fffffff lat=33", r, lat);
        end
    endtask

    task automatic test_special();
        logic [31:0] r; int lat; bit bok, pok;
        do_op32(3'd4, 32'd7, 32'd0, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'hFFFF_FFFF || lat != 1 || !pok) begin
            n_fail++;
            $display("FAIL div_by_zero: got res=%h lat=%0d post=%b want ffffffff lat=1", r, lat, pok);
        end
        do_op32(3'd6, 32'd7, 32'd0, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'd7 || lat != 1) begin
            n_fail++;
            $display("FAIL rem_by_zero: got res=%h lat=%0d want 00000007 lat=1", r, lat);
        end
        do_op32(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'h8000_0000 || lat != 1) begin
            n_fail++;
            $display("FAIL div_overflow: got res=%h lat=%0d want 80000000 lat=1", r, lat);
        end
        do_op32(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'd0 || lat != 1) begin
            n_fail++;
            $display("FAIL rem_overflow: got res=%h lat=%0d want 00000000 lat=1", r, lat);
        end
    endtask

    task automatic test_ignore_start();
        int ndone, first;
        logic [31:0] r;
        start32 = 1'b1; op32 = 3'd0; a32 = 32'd3; b32 = 32'd5;
        @(posedge clk); #1;
        start32 = 1'b0;
        ndone = 0; first = -1; r = '0;
        for (int c = 1; c <= 45; c++) begin
            if (done32 === 1'b1) begin
                ndone++;
                if (first < 0) begin first = c; r = res32; end
            end
            if (c == 5) begin start32 = 1'b1; op32 = 3'd0; a32 = 32'd7; b32 = 32'd9; end
            if (c == 6) start32 = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (ndone != 1 || first != 33 || r !== 32'd15) begin
            n_fail++;
            $display("FAIL start_while_busy: got dones=%0d at=%0d res=%h want 1 at 33 res 0000000f",
                     ndone, first, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat; bit bok, pok;
        do_op32(3'd0, 32'd6, 32'd7, r, lat, bok, pok);
        do_op32(3'd5, 32'd100, 32'd7, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'd14 || lat != 33) begin
            n_fail++;
            $display("FAIL b2b_normal: got res=%h lat=%0d want 0000000e lat=33", r, lat);
        end
        do_op32(3'd5, 32'd9, 32'd0, r, lat, bok, pok);
        do_op32(3'd7, 32'd9, 32'd0, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'd9 || lat != 1) begin
            n_fail++;
            $display("FAIL b2b_special: got res=%h lat=%0d want 00000009 lat=1", r, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat; bit bok, pok;
        int ndone;
        start32 = 1'b1; op32 = 3'd4; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({busy32, done32, res32} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got busy=%b done=%b res=%h want 0/0/0", busy32, done32, res32);
        end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done32 === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", ndone);
        end
        do_op32(3'd0, 32'd3, 32'd4, r, lat, bok, pok);
        n_checks++;
        if (r !== 32'd12 || lat != 33) begin
            n_fail++;
            $display("FAIL mul_after_reset: got res=%h lat=%0d want 0000000c lat=33", r, lat);
        end
    endtask

    task automatic test_xlen8();
        logic [7:0] r; int lat; bit bok, pok;
        do_op8(3'd0, 8'h10, 8'h10, r, lat, bok, pok);
        n_checks++;
        if (r !== 8'h00 || lat != 9 || !bok || !pok) begin
            n_fail++;
            $display("FAIL x8_mul_wrap: got res=%h lat=%0d busy_ok=%b post=%b want 00 lat=9", r, lat, bok, pok);
        end
        do_op8(3'd3, 8'h10, 8'h10, r, lat, bok, pok);
        n_checks++;
        if (r !== 8'h01 || lat != 9) begin
            n_fail++;
            $display("FAIL x8_mulhu: got res=%h lat=%0d want 01 lat=9", r, lat);
        end
        do_op8(3'd0, 8'hF0, 8'hFB, r, lat, bok, pok);
        n_checks++;
        if (r !== 8'h50 || lat != 9) begin
            n_fail++;
            $display("FAIL x8_mul_neg: got res=%h lat=%0d want 50 lat=9", r, lat);
        end
        do_op8(3'd4, 8'hEB, 8'd5, r, lat, bok, pok);
        n_checks++;
        if (r !== 8'hFC || lat != 9) begin
            n_fail++;
            $display("FAIL x8_div: got res=%h lat=%0d want fc lat=9", r, lat);
        end
        do_op8(3'd6, 8'hEB, 8'd5, r, lat, bok, pok);
        n_checks++;
        if (r !== 8'hFF || lat != 9) begin
            n_fail++;
            $display("FAIL x8_rem: got res=%h lat=%0d want ff lat=9", r, lat);
        end
        do_op8(3'd4, 8'h80, 8'hFF, r, lat, bok, pok);
        n_checks++;
        if (r !== 8'h80 || lat != 1) begin
            n_fail++;
            $display("FAIL x8_div_overflow: got res=%h lat=%0d want 80 lat=1", r, lat);
        end
    endtask

    task automatic test_random32();
        logic [31:0] a, b, r, exp; logic [2:0] op; int lat, el; bit bok, pok;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            exp = 32'(model(32, op, {32'd0, a}, {32'd0, b}));
            el  = exp_lat(32, op, {32'd0, a}, {32'd0, b});
            do_op32(op, a, b, r, lat, bok, pok);
            n_checks++;
            if (r !== exp || lat != el || !bok || !pok) begin
                n_fail++;
                $display("FAIL rand32 op=%0d a=%h b=%h: got res=%h lat=%0d ok=%b%b want res=%h lat=%0d",
                         op, a, b, r, lat, bok, pok, exp, el);
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0] a, b, r, exp; logic [2:0] op; int lat, el; bit bok, pok;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 8'($urandom); b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 8'h80; b = '1; end
                default: ;
            endcase
            exp = 8'(model(8, op, {56'd0, a}, {56'd0, b}));
            el  = exp_lat(8, op, {56'd0, a}, {56'd0, b});
            do_op8(op, a, b, r, lat, bok, pok);
            n_checks++;
            if (r !== exp || lat != el || !bok || !pok) begin
                n_fail++;
                $display("FAIL rand8 op=%0d a=%h b=%h: got res=%h lat=%0d ok=%b%b want res=%h lat=%0d",
                         op, a, b, r, lat, bok, pok, exp, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_xlen8();
        test_random32();
        test_random8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
